// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state encoding, default widths and power-on memory image (DMEM_INIT_EN)
package dmem_pkg;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_e;

   localparam int DMEM_DATA_W  = 8;
   localparam int DMEM_ADDR_W  = 8;
   localparam int DMEM_DEPTH   = 16;
   localparam int DMEM_LATENCY = 2;

   localparam logic [7:0] DMEM_INIT_W0 = 8'hEC;
   localparam logic [7:0] DMEM_INIT_W1 = 8'h0A;
   localparam logic [7:0] DMEM_INIT_W2 = 8'h02;

   function automatic logic [7:0] dmem_init_word(input int idx);
      return (idx == 0) ? DMEM_INIT_W0 :
             (idx == 1) ? DMEM_INIT_W1 :
             (idx == 2) ? DMEM_INIT_W2 : 8'h00;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between an initiator (master) and the responder (slave)
interface dmem_responder_if
   import dmem_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with one synchronous write port and one combinational read port; DMEM_INIT_EN adds a reset image
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int DEPTH  = DMEM_DEPTH,
   parameter int IW     = 4
) (
   input  logic              clk,
`ifdef DMEM_INIT_EN
   input  logic              rst_n,
`endif
   input  logic              we,
   input  logic [IW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[raddr];

`ifdef DMEM_INIT_EN
   // reset loads the fixed memory image, otherwise commit writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(dmem_init_word(i));
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end
`else
   // storage is never reset; only commit writes
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency memory responder (IDLE/WAIT/RESP FSM) in front of dmem_array; optional DMEM_INIT_EN reset image
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W  = DMEM_DATA_W,
   parameter int ADDR_W  = DMEM_ADDR_W,
   parameter int DEPTH   = DMEM_DEPTH,
   parameter int LATENCY = DMEM_LATENCY
) (
   input logic              clk,
   input logic              rst_n,
   dmem_responder_if.slave  bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] ST_IDLE = 2'(DMEM_IDLE);
   localparam logic [1:0] ST_WAIT = 2'(DMEM_WAIT);
   localparam logic [1:0] ST_RESP = 2'(DMEM_RESP);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              hold_write;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic [DATA_W-1:0] rd_word;
   logic              idle;
   logic              accept;
   logic              enter_resp;
   logic              cur_write;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic              in_range;
   logic              we;

   // with LATENCY==1 the commit edge is the acceptance edge, so the live request is used instead of the holding registers
   assign idle       = (state == ST_IDLE);
   assign accept     = idle && bus.req_valid;
   assign cur_write  = idle ? bus.req_write : hold_write;
   assign cur_addr   = idle ? bus.req_addr  : hold_addr;
   assign cur_wdata  = idle ? bus.req_wdata : hold_wdata;
   assign in_range   = {1'b0, cur_addr} < DEPTH_C;
   assign enter_resp = (accept && (LATENCY == 1)) || ((state == ST_WAIT) && (cnt == 4'd1));
   assign we         = enter_resp && cur_write && in_range;

   assign bus.req_ready  = idle;
   assign bus.resp_valid = (state == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
      .clk   (clk),
`ifdef DMEM_INIT_EN
      .rst_n (rst_n),
`endif
      .we    (we),
      .waddr (cur_addr[IW-1:0]),
      .wdata (cur_wdata),
      .raddr (cur_addr[IW-1:0]),
      .rdata (rd_word)
   );

   // FSM and latency down-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (accept) begin
         state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
         cnt   <= CNT_LOAD;
      end else if (state == ST_WAIT) begin
         cnt   <= cnt - 4'd1;
         state <= (cnt == 4'd1) ? ST_RESP : ST_WAIT;
      end else if ((state == ST_RESP) && bus.resp_ready) begin
         state <= ST_IDLE;
      end
   end

   // capture the accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_write <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
      end else if (accept) begin
         hold_write <= bus.req_write;
         hold_addr  <= bus.req_addr;
         hold_wdata <= bus.req_wdata;
      end
   end

   // response payload is sampled only on the edge entering RESP and held until the handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         rdata_q <= !in_range ? '0 : (cur_write ? cur_wdata : rd_word);
         err_q   <= !in_range;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY=2 (dut_a) and LATENCY=1 (dut_b)
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic       rv [2];
   logic       rw [2];
   logic       rr [2];
   logic [7:0] ra [2];
   logic [7:0] rwd [2];
   logic       q_ready [2];
   logic       q_valid [2];
   logic       q_err [2];
   logic [7:0] q_rdata [2];

   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_W(8), .ADDR_W(8)) ia ();
   dmem_responder_if #(.DATA_W(8), .ADDR_W(8)) ib ();

   assign ia.req_valid  = rv[0];
   assign ia.req_write  = rw[0];
   assign ia.req_addr   = ra[0];
   assign ia.req_wdata  = rwd[0];
   assign ia.resp_ready = rr[0];
   assign ib.req_valid  = rv[1];
   assign ib.req_write  = rw[1];
   assign ib.req_addr   = ra[1];
   assign ib.req_wdata  = rwd[1];
   assign ib.resp_ready = rr[1];
   assign q_ready[0] = ia.req_ready;
   assign q_valid[0] = ia.resp_valid;
   assign q_err[0]   = ia.resp_err;
   assign q_rdata[0] = ia.resp_rdata;
   assign q_ready[1] = ib.req_ready;
   assign q_valid[1] = ib.resp_valid;
   assign q_err[1]   = ib.resp_err;
   assign q_rdata[1] = ib.resp_rdata;

   dmem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .LATENCY(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ia)
   );
   dmem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .LATENCY(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ib)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int s, input logic w, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      rv[s] = 1'b1; rw[s] = w; ra[s] = a; rwd[s] = d;
      chk("req_ready_before_accept", 32'(q_ready[s]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rv[s] = 1'b0;
   endtask

   task automatic wait_resp(input int s, input int lat, input string tag);
      int n = 1;
      while (!q_valid[s] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(lat));
   endtask

   task automatic check_resp(input int s, input string tag, input logic [7:0] d, input logic e);
      chk({tag, "_rdata"}, 32'(q_rdata[s]), 32'(d));
      chk({tag, "_err"}, 32'(q_err[s]), 32'(e));
   endtask

   task automatic release_resp(input int s, input string tag);
      rr[s] = 1'b1;
      @(negedge clk);
      rr[s] = 1'b0;
      chk({tag, "_idle_ready"}, 32'(q_ready[s]), 32'd1);
      chk({tag, "_idle_valid"}, 32'(q_valid[s]), 32'd0);
   endtask

   task automatic txn(input int s, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int lat, input logic [7:0] exp_d, input logic exp_e, input string tag);
      send(s, w, a, d);
      wait_resp(s, lat, tag);
      check_resp(s, tag, exp_d, exp_e);
      release_resp(s, tag);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         rv[s] = 1'b0; rw[s] = 1'b0; rr[s] = 1'b0; ra[s] = 8'h00; rwd[s] = 8'h00;
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_req_ready", 32'(q_ready[s]), 32'd1);
         chk("rst_resp_valid", 32'(q_valid[s]), 32'd0);
         chk("rst_resp_rdata", 32'(q_rdata[s]), 32'd0);
         chk("rst_resp_err", 32'(q_err[s]), 32'd0);
      end
      rst_n = 1'b1;

`ifdef DMEM_INIT_EN
      txn(0, 1'b0, 8'd1, 8'h00, 2, 8'h0A, 1'b0, "init_load1");
      txn(1, 1'b0, 8'd0, 8'h00, 1, 8'hEC, 1'b0, "lat1_init_load0");
`else
      txn(0, 1'b1, 8'd1, 8'h0A, 2, 8'h0A, 1'b0, "store1");
      txn(0, 1'b0, 8'd1, 8'h00, 2, 8'h0A, 1'b0, "load1");
`endif
      txn(1, 1'b1, 8'd0, 8'h5A, 1, 8'h5A, 1'b0, "lat1_store0");
      txn(1, 1'b0, 8'd0, 8'h00, 1, 8'h5A, 1'b0, "lat1_load0");

      txn(0, 1'b1, 8'd5, 8'h3C, 2, 8'h3C, 1'b0, "store5");
      txn(0, 1'b0, 8'd5, 8'h00, 2, 8'h3C, 1'b0, "load5");
      txn(0, 1'b1, 8'd7, 8'hA5, 2, 8'hA5, 1'b0, "store7");
      txn(0, 1'b1, 8'd15, 8'h81, 2, 8'h81, 1'b0, "store15");
      txn(0, 1'b0, 8'd7, 8'h00, 2, 8'hA5, 1'b0, "load7");
      txn(0, 1'b0, 8'd15, 8'h00, 2, 8'h81, 1'b0, "load15");

      txn(0, 1'b1, 8'd4, 8'h11, 2, 8'h11, 1'b0, "store4");
      txn(0, 1'b0, 8'd20, 8'h00, 2, 8'h00, 1'b1, "load20_oor");
      txn(0, 1'b0, 8'd16, 8'h00, 2, 8'h00, 1'b1, "load16_oor");
      txn(0, 1'b1, 8'd20, 8'h77, 2, 8'h00, 1'b1, "store20_oor");
      txn(0, 1'b0, 8'd4, 8'h00, 2, 8'h11, 1'b0, "load4_unchanged");

      send(0, 1'b0, 8'd5, 8'h00);
      wait_resp(0, 2, "stall");
      check_resp(0, "stall", 8'h3C, 1'b0);
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 8'd5; rwd[0] = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(q_valid[0]), 32'd1);
         chk("stall_rdata", 32'(q_rdata[0]), 32'h3C);
         chk("stall_req_ready", 32'(q_ready[0]), 32'd0);
      end
      rr[0] = 1'b1;
      @(negedge clk);
      rr[0] = 1'b0;
      rv[0] = 1'b0;
      chk("hs_idle_ready", 32'(q_ready[0]), 32'd1);
      @(negedge clk);
      chk("no_accept_on_hs_ready", 32'(q_ready[0]), 32'd1);
      chk("no_accept_on_hs_valid", 32'(q_valid[0]), 32'd0);
      txn(0, 1'b0, 8'd5, 8'h00, 2, 8'h3C, 1'b0, "load5_after_stall");

      txn(0, 1'b1, 8'd3, 8'h42, 2, 8'h42, 1'b0, "store3");
      send(0, 1'b1, 8'd3, 8'h99);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(q_valid[0]), 32'd0);
      chk("midrst_ready", 32'(q_ready[0]), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("postrst_valid", 32'(q_valid[0]), 32'd0);
      chk("postrst_ready", 32'(q_ready[0]), 32'd1);
`ifdef DMEM_INIT_EN
      txn(0, 1'b0, 8'd3, 8'h00, 2, 8'h00, 1'b0, "load3_after_rst");
`else
      txn(0, 1'b0, 8'd3, 8'h00, 2, 8'h42, 1'b0, "load3_after_rst");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
